// File: rtl/display_pkg.sv
// Shared types and constants for the display RAM writer and its sweep counter.
package display_pkg;

  typedef enum logic [1:0] {
    OP_WRITE       = 2'd0,
    OP_CLEAR       = 2'd1,
    OP_FILL        = 2'd2,
    OP_SET_DISPLAY = 2'd3
  } disp_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DONE  = 2'd3
  } disp_state_t;

  localparam int DISP_DEPTH    = 32'd65;
  localparam int DISP_SEL_ADDR = 32'd64;

endpackage

// File: rtl/sweep_counter.sv
// Address counter for CLEAR/FILL sweeps; advances only on granted edges and
// wraps to zero after the last cell.
module sweep_counter #(
  parameter int AW    = 8,
  parameter int DEPTH = 65
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [AW-1:0] count,
  output logic          last
);

  localparam logic [AW-1:0] LP_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LP_ONE  = AW'(1);

  logic [AW-1:0] r_count;

  assign count = r_count;
  assign last  = (r_count == LP_LAST);

  // Count register: held at zero outside a sweep, wraps after the last cell.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= {AW{1'b0}};
    end else if (clear) begin
      r_count <= {AW{1'b0}};
    end else if (en) begin
      if (last) begin
        r_count <= {AW{1'b0}};
      end else begin
        r_count <= r_count + LP_ONE;
      end
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/display_ram_writer.sv
// Command-driven second write initiator for the VGA display RAM. All outputs
// are registered; the CPU keeps priority on the RAM port through mem_grant.
module display_ram_writer
  import display_pkg::*;
#(
  parameter int DEPTH        = DISP_DEPTH,
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int DISPLAY_ADDR = DISP_SEL_ADDR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic          mem_grant,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] LP_DEPTH    = AW'(DEPTH);
  localparam logic [AW-1:0] LP_SEL_ADDR = AW'(DISPLAY_ADDR);
  localparam logic [AW-1:0] LP_ONE      = AW'(1);

  disp_state_t   r_state;
  logic          r_cmd_ready;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_we;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  disp_op_t      w_op;
  logic [AW-1:0] w_cnt;
  logic          w_last;
  logic          w_cnt_en;
  logic          w_cnt_clear;

  assign w_op        = disp_op_t'(cmd_op);
  assign w_cnt_en    = (r_state == ST_SWEEP) && mem_grant;
  assign w_cnt_clear = (r_state != ST_SWEEP);

  sweep_counter #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_sweep_counter (
    .clk   (clk),
    .reset (reset),
    .clear (w_cnt_clear),
    .en    (w_cnt_en),
    .count (w_cnt),
    .last  (w_last)
  );

  // Command FSM; the address/data output registers double as the command latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_mem_addr  <= {AW{1'b0}};
      r_mem_wdata <= {DW{1'b0}};
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            case (w_op)
              OP_WRITE: begin
                r_state     <= ST_WRITE;
                r_mem_addr  <= cmd_addr;
                r_mem_wdata <= cmd_data;
                // An out-of-range target never raises the write request.
                r_mem_we    <= (cmd_addr < LP_DEPTH);
              end
              OP_SET_DISPLAY: begin
                r_state     <= ST_WRITE;
                r_mem_addr  <= LP_SEL_ADDR;
                r_mem_wdata <= cmd_data;
                r_mem_we    <= 1'b1;
              end
              OP_CLEAR: begin
                r_state     <= ST_SWEEP;
                r_mem_addr  <= {AW{1'b0}};
                r_mem_wdata <= {DW{1'b0}};
                r_mem_we    <= 1'b1;
              end
              OP_FILL: begin
                r_state     <= ST_SWEEP;
                r_mem_addr  <= {AW{1'b0}};
                r_mem_wdata <= cmd_data;
                r_mem_we    <= 1'b1;
              end
              default: begin
                r_state     <= ST_IDLE;
                r_cmd_ready <= 1'b1;
                r_busy      <= 1'b0;
              end
            endcase
          end
        end
        ST_WRITE: begin
          if (!r_mem_we) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else if (mem_grant) begin
            r_state  <= ST_DONE;
            r_mem_we <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (mem_grant) begin
            if (w_last) begin
              r_state    <= ST_DONE;
              r_mem_we   <= 1'b0;
              r_mem_addr <= {AW{1'b0}};
              r_done     <= 1'b1;
            end else begin
              r_mem_addr <= w_cnt + LP_ONE;
            end
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_err       <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
          r_mem_we    <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_err       <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_display_ram_writer.sv
// Directed plus randomized bench for display_ram_writer against a RAM-level
// command model kept in the bench.
module tb_display_ram_writer;

  localparam int DEPTH = 65;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_grant;
  logic       busy;
  logic       done;
  logic       err;

  int vectors;
  int miscompares;

  logic [7:0] ram     [0:DEPTH-1];
  logic [7:0] ram_ref [0:DEPTH-1];
  int         wcnt    [0:DEPTH-1];
  int         total_writes;
  int         oor_writes;

  display_ram_writer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_grant (mem_grant),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display RAM: commits whatever the write port presents on a granted edge.
  always @(posedge clk) begin
    if (reset && mem_we && mem_grant) begin
      total_writes = total_writes + 1;
      if (mem_addr < 8'd65) begin
        ram[mem_addr]  = mem_wdata;
        wcnt[mem_addr] = wcnt[mem_addr] + 1;
      end else begin
        oor_writes = oor_writes + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("%s ram[%0d]", tag, i), ram[i], ram_ref[i]);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    chk("ready_before_handshake", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_addr  = 8'($urandom);
    cmd_data  = 8'($urandom);
  endtask

  // gmode: 0 = grant held high, 1 = grant 1,0,1,0..., 2 = random grant
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] data,
                        input int gmode, input string tag);
    bit         sweep;
    bit         oor;
    int         needed;
    int         commits;
    int         lows;
    int         done_cyc;
    int         writes0;
    logic [7:0] exp_data;
    logic [7:0] exp_addr;
    logic       g;

    sweep    = (op == 2'd1) || (op == 2'd2);
    oor      = (op == 2'd0) && (addr >= 8'd65);
    needed   = oor ? 0 : (sweep ? DEPTH : 1);
    exp_data = (op == 2'd1) ? 8'h00 : data;
    commits  = 0;
    lows     = 0;
    done_cyc = 0;
    for (int i = 0; i < DEPTH; i++) wcnt[i] = 0;
    writes0 = total_writes;

    send(op, addr, data);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      chk({tag, " busy"}, busy, 1'b1);
      chk({tag, " ready_low"}, cmd_ready, 1'b0);
      if (oor) begin
        chk({tag, " no_we"}, mem_we, 1'b0);
      end else begin
        exp_addr = sweep ? 8'(commits) : ((op == 2'd3) ? 8'd64 : addr);
        chk({tag, " we"}, mem_we, 1'b1);
        chk({tag, " addr"}, mem_addr, exp_addr);
        chk({tag, " wdata"}, mem_wdata, exp_data);
      end
      if (gmode == 0)      g = 1'b1;
      else if (gmode == 1) g = (cyc % 2 == 1);
      else                 g = ($urandom_range(0, 3) != 0);
      mem_grant = g;
      if (!oor) begin
        if (g) commits = commits + 1;
        else   lows    = lows + 1;
      end
    end
    mem_grant = 1'b1;

    chk({tag, " done_seen"}, (done_cyc != 0), 1'b1);
    chk({tag, " done_cycle"}, done_cyc, oor ? 2 : needed + 1 + lows);
    chk({tag, " err"}, err, oor);
    chk({tag, " we_at_done"}, mem_we, 1'b0);
    chk({tag, " ready_at_done"}, cmd_ready, 1'b0);

    if (op == 2'd0 && !oor) ram_ref[addr] = data;
    if (op == 2'd3)         ram_ref[64]   = data;
    if (sweep) for (int i = 0; i < DEPTH; i++) ram_ref[i] = exp_data;

    chk({tag, " write_count"}, total_writes - writes0, needed);
    chk({tag, " oor_writes"}, oor_writes, 0);
    if (sweep) begin
      for (int i = 0; i < DEPTH; i++) chk($sformatf("%s once[%0d]", tag, i), wcnt[i], 1);
      chk({tag, " counter_zero"}, dut.u_sweep_counter.count, 8'd0);
    end
    check_ram(tag);

    @(negedge clk);
    chk({tag, " done_pulse"}, done, 1'b0);
    chk({tag, " err_pulse"}, err, 1'b0);
    chk({tag, " ready_after"}, cmd_ready, 1'b1);
    chk({tag, " busy_after"}, busy, 1'b0);
  endtask

  initial begin
    int writes0;
    bit found;
    vectors      = 0;
    miscompares  = 0;
    total_writes = 0;
    oor_writes   = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 8'h00;
      ram_ref[i] = 8'h00;
      wcnt[i]    = 0;
    end
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 8'd0;
    cmd_data  = 8'd0;
    mem_grant = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst cmd_ready", cmd_ready, 1'b1);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst mem_addr", mem_addr, 8'd0);
    chk("rst mem_wdata", mem_wdata, 8'd0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst err", err, 1'b0);
    reset = 1'b1;

    do_cmd(2'd0, 8'd5, 8'hA5, 0, "write5");
    chk("ram5_A5", ram[5], 8'hA5);
    do_cmd(2'd3, 8'd9, 8'h03, 0, "setdisp");
    chk("selector_03", ram[64], 8'h03);
    chk("addr9_untouched", ram[9], 8'h00);
    do_cmd(2'd2, 8'd0, 8'h7E, 0, "fill7E");
    do_cmd(2'd1, 8'd0, 8'h00, 1, "clear_toggle");
    do_cmd(2'd0, 8'd70, 8'h11, 0, "write_oor");
    do_cmd(2'd0, 8'd64, 8'h22, 1, "write_last");
    do_cmd(2'd0, 8'd65, 8'h33, 2, "write_depth");

    // Reset in the middle of a FILL, while address 20 is pending.
    send(2'd2, 8'd0, 8'h5C);
    found = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (mem_addr === 8'd20) begin
        found = 1'b1;
        break;
      end
    end
    chk("midreset reached_20", found, 1'b1);
    reset = 1'b0;
    #1;
    chk("midreset mem_we", mem_we, 1'b0);
    chk("midreset mem_addr", mem_addr, 8'd0);
    chk("midreset cmd_ready", cmd_ready, 1'b1);
    chk("midreset busy", busy, 1'b0);
    chk("midreset done", done, 1'b0);
    writes0 = total_writes;
    for (int i = 0; i < 20; i++) ram_ref[i] = 8'h5C;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("postreset cmd_ready", cmd_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("postreset no_writes", total_writes - writes0, 0);
    chk("postreset mem_we", mem_we, 1'b0);
    check_ram("midreset");

    for (int n = 0; n < 12; n++) begin
      do_cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 80)), 8'($urandom),
             int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_ram_writer.md
# display_ram_writer

Command-driven writer for the 65-byte display RAM that the VGA controller scans, with byte 64 holding the display selector. It accepts single-byte write, clear, fill and display-select commands over a valid/ready handshake and issues byte writes on the RAM write port (address, data, write-enable). The CPU store path keeps priority through `mem_grant`. It sits beside the CPU as a second write initiator for the region the VGA side reads.

## Interface
- `DEPTH`, default 65: number of display RAM cells, addresses 0..DEPTH-1.
- `AW`, default 8: address width.
- `DW`, default 8: data width.
- `DISPLAY_ADDR`, default 64: address of the display-selector byte.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  2  0=WRITE, 1=CLEAR, 2=FILL, 3=SET_DISPLAY.
- `cmd_addr`  in  AW  target cell (WRITE only).
- `cmd_data`  in  DW  byte for WRITE, FILL or SET_DISPLAY.
- `mem_addr`  out  AW  RAM write address.
- `mem_wdata`  out  DW  RAM write data.
- `mem_we`  out  1  write request.
- `mem_grant`  in  1  port free this cycle (low while the CPU `MemWrite` is active).
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse with `done`: WRITE target out of range.

## Operation
- States: IDLE, WRITE, SWEEP, DONE.
- IDLE
  - `cmd_ready`=1.
  - A handshake (`cmd_valid`&&`cmd_ready`) latches op, addr and data.
  - Next state: WRITE for WRITE or SET_DISPLAY, SWEEP for CLEAR or FILL.
- WRITE
  - Drives `mem_addr`: the latched addr, or `DISPLAY_ADDR` for SET_DISPLAY.
  - Drives `mem_wdata` from the latched data, with `mem_we`=1.
  - A write commits on an edge where `mem_we`&&`mem_grant`; the block then goes to DONE.
  - With `mem_grant`=0 it holds all outputs unchanged.
- WRITE with latched addr >= DEPTH: no `mem_we`; go directly to DONE with `err`=1.
- SWEEP
  - Counter starts at 0; `mem_addr`=counter, `mem_we`=1.
  - `mem_wdata` is 0 for CLEAR and the latched data for FILL.
  - Counter increments only on granted edges.
  - After the commit at DEPTH-1 the counter wraps to 0 and the state goes to DONE.
  - CLEAR and FILL include `DISPLAY_ADDR`.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in WRITE, SWEEP and DONE.
- Commands are not queued. `cmd_valid` while `cmd_ready`=0 is ignored; the sender must hold it.
- Width rules
  - Addresses are compared unsigned at full AW.
  - Counter width is AW; it never exceeds DEPTH-1.

## Timing
- Reset values: `cmd_ready`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `err`=0, state IDLE, counter 0.
- Reset asserted mid-command: immediate abort, outputs take reset values, no further writes. A write not yet committed is lost.
- All outputs are Moore (decoded from registered state, counter and latches). No combinational path from `cmd_*` or `mem_grant` to any output.
- Single WRITE with grant held high:
  - handshake at edge 0;
  - `mem_we` high during cycle 1, commit at edge 1;
  - `done` during cycle 2;
  - `cmd_ready` during cycle 3.
- CLEAR/FILL with grant high: `mem_we` high for DEPTH consecutive cycles (1..DEPTH), `done` in cycle DEPTH+1.
- Each cycle with `mem_grant`=0 during WRITE or SWEEP adds exactly one cycle of latency.
- Handshake and latch share one edge; `cmd_*` may change on the following cycle.

## Structure
- Shared package `display_pkg`:
  - `disp_op_t` enum (WRITE, CLEAR, FILL, SET_DISPLAY);
  - `disp_state_t`;
  - constants `DISP_DEPTH`=65 and `DISP_SEL_ADDR`=64.
- Sub-module `sweep_counter`: AW-bit counter with `clear`, `en`, `last` (count == DEPTH-1), wrapping to 0.
- The FSM, latches and output decode stay in `display_ram_writer`.

## Test plan
- Reset, then WRITE addr=5 data=8'hA5, grant=1 -> one `mem_we` cycle at addr 5 data A5; `done` two cycles after handshake; RAM[5]=A5.
- SET_DISPLAY data=8'h03 with cmd_addr=9 -> single write at addr 64 data 03; addr 9 untouched; VGA selector reads 03.
- FILL data=8'h7E with grant=1 -> 65 consecutive writes, addr 0..64, all 7E; `done` in cycle 66; counter back to 0.
- CLEAR with grant toggling 1,0,1,0 -> every address 0..64 written exactly once with 00; total `mem_we` cycles = 65 + number of grant-low cycles.
- WRITE addr=70 -> `mem_we` never asserted; `done`=`err`=1 in the same cycle; next command accepted normally.
- Reset asserted at SWEEP addr 20 -> outputs at reset values immediately; no writes after deassertion; `cmd_ready`=1 on the first cycle after deassertion.
